// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// default terminator word and bytes per instruction.
package program_loader_pkg;

    localparam int unsigned BYTES_PER_WORD   = 2;
    localparam logic [15:0] END_WORD_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        WRITE,
        FINISH,
        DONE,
        READBACK
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream handshake plus instruction-memory write bus. The master modport
// is the loader side; the slave modport is the byte source / processor side.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);

    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] instruct_dir;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output we,
        output instruction,
        output instruct_dir
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  we,
        input  instruction,
        input  instruct_dir
    );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Collects byte pairs (high byte first) into one instruction word and
// generates the registered byte_ready from the FSM's next-state request.
module program_loader_byte_packer
    import program_loader_pkg::*;
#(
    parameter int unsigned DATA_W = BYTES_PER_WORD * 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              collect_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              hi_taken_o,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    logic       ready_q, ready_d;
    logic       lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic       take;

    assign take = byte_valid_i & ready_q;

    always_comb begin
        ready_d = collect_i;
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (take) begin
            if (!lo_q) begin
                hi_d = byte_in_i;
                lo_d = 1'b1;
            end else begin
                lo_d = 1'b0;
            end
        end
        if (!collect_i) begin
            lo_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            lo_q    <= 1'b0;
            hi_q    <= '0;
        end else begin
            ready_q <= ready_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign hi_taken_o   = take & ~lo_q;
    assign word_valid_o = take & lo_q;
    assign word_o       = {hi_q, byte_in_i};

endmodule

// File: rtl/program_loader.sv
// Host-side instruction loader: streams byte pairs into instruction memory
// and pulses finish. Optional readback phase under PROGRAM_LOADER_READBACK_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] END_WORD = END_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    program_loader_if.master  bus,
    output logic              finish,
    output logic              busy,
    output logic [ADDR_W:0]   loaded_count,
    output logic              truncated
`ifdef PROGRAM_LOADER_READBACK_EN
    ,
    output logic              read_enable,
    output logic [1:0]        read_address,
    output logic [7:0]        rb_data,
    output logic              rb_valid,
    input  logic [7:0]        register
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LC_ONE    = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     lc_q, lc_d;
    logic                trunc_q, trunc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   dir_q, dir_d;
    logic                we_q, we_d;
    logic                finish_q, finish_d;
    logic                busy_q, busy_d;
    logic                collect;
    logic                hi_taken;
    logic                word_valid;
    logic [DATA_W-1:0]   word;

`ifdef PROGRAM_LOADER_READBACK_EN
    logic [1:0] rb_addr_q, rb_addr_d;
    logic       rb_phase_q, rb_phase_d;
    logic       rd_en_q, rd_en_d;
    logic [7:0] rb_data_q, rb_data_d;
    logic       rb_valid_q, rb_valid_d;
`endif

    program_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .collect_i    (collect),
        .byte_in_i    (bus.byte_in),
        .byte_valid_i (bus.byte_valid),
        .byte_ready_o (bus.byte_ready),
        .hi_taken_o   (hi_taken),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lc_d    = lc_q;
        trunc_d = trunc_q;
        instr_d = instr_q;
        dir_d   = dir_q;
`ifdef PROGRAM_LOADER_READBACK_EN
        rb_addr_d  = rb_addr_q;
        rb_phase_d = rb_phase_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = GET_HI;
                    addr_d  = '0;
                    lc_d    = '0;
                    trunc_d = 1'b0;
                end
            end
            GET_HI: begin
                if (hi_taken) begin
                    state_d = GET_LO;
                end
            end
            GET_LO: begin
                if (word_valid) begin
                    if (word == END_WORD) begin
                        state_d = FINISH;
                    end else begin
                        state_d = WRITE;
                        instr_d = word;
                        dir_d   = addr_q;
                    end
                end
            end
            WRITE: begin
                lc_d = lc_q + LC_ONE;
                // Ending here at the last slot is what keeps addr from ever wrapping.
                if (addr_q == LAST_ADDR) begin
                    trunc_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = GET_HI;
                end
            end
            FINISH: begin
`ifdef PROGRAM_LOADER_READBACK_EN
                state_d    = READBACK;
                rb_addr_d  = '0;
                rb_phase_d = 1'b0;
`else
                state_d = DONE;
`endif
            end
`ifdef PROGRAM_LOADER_READBACK_EN
            READBACK: begin
                // Each address is held two cycles; capture on the second one.
                if (!rb_phase_q) begin
                    rb_phase_d = 1'b1;
                end else begin
                    rb_phase_d = 1'b0;
                    rb_data_d  = register;
                    rb_valid_d = 1'b1;
                    if (rb_addr_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        rb_addr_d = rb_addr_q + 2'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    assign collect  = (state_d == GET_HI) || (state_d == GET_LO);
    assign we_d     = (state_d == WRITE);
    assign finish_d = (state_d == FINISH);
    assign busy_d   = (state_d != IDLE) && (state_d != DONE);
`ifdef PROGRAM_LOADER_READBACK_EN
    assign rd_en_d  = (state_d == READBACK);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            lc_q     <= '0;
            trunc_q  <= 1'b0;
            instr_q  <= '0;
            dir_q    <= '0;
            we_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef PROGRAM_LOADER_READBACK_EN
            rb_addr_q  <= '0;
            rb_phase_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lc_q     <= lc_d;
            trunc_q  <= trunc_d;
            instr_q  <= instr_d;
            dir_q    <= dir_d;
            we_q     <= we_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
`ifdef PROGRAM_LOADER_READBACK_EN
            rb_addr_q  <= rb_addr_d;
            rb_phase_q <= rb_phase_d;
            rd_en_q    <= rd_en_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
`endif
        end
    end

    assign bus.we           = we_q;
    assign bus.instruction  = instr_q;
    assign bus.instruct_dir = dir_q;
    assign finish           = finish_q;
    assign busy             = busy_q;
    assign loaded_count     = lc_q;
    assign truncated        = trunc_q;
`ifdef PROGRAM_LOADER_READBACK_EN
    assign read_enable  = rd_en_q;
    assign read_address = rb_addr_q;
    assign rb_data      = rb_data_q;
    assign rb_valid     = rb_valid_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a vector table of load sessions plus
// hand sequences for latency, reset mid-load and DEPTH overflow.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       sel4;

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(8), .DATA_W(16)) b0 ();
    program_loader_if #(.ADDR_W(8), .DATA_W(16)) b4 ();

    assign b0.byte_in    = byte_in;
    assign b0.byte_valid = byte_valid;
    assign b4.byte_in    = byte_in;
    assign b4.byte_valid = byte_valid;

    logic       fin0, busy0, tr0, fin4, busy4, tr4;
    logic [8:0] lc0, lc4;

`ifdef PROGRAM_LOADER_READBACK_EN
    logic       re0, rv0, re4, rv4;
    logic [1:0] ra0, ra4;
    logic [7:0] rd0, rd4, reg0, reg4;
    logic [3:0] n0, n4;
    assign n0   = {2'b00, ra0} + 4'd1;
    assign n4   = {2'b00, ra4} + 4'd1;
    assign reg0 = {n0, 4'h0};
    assign reg4 = {n4, 4'h0};
`endif

    program_loader #(
        .ADDR_W(8), .DATA_W(16), .DEPTH(256), .END_WORD(16'hFFFF)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(b0),
        .finish(fin0), .busy(busy0), .loaded_count(lc0), .truncated(tr0)
`ifdef PROGRAM_LOADER_READBACK_EN
        , .read_enable(re0), .read_address(ra0), .rb_data(rd0),
        .rb_valid(rv0), .register(reg0)
`endif
    );

    program_loader #(
        .ADDR_W(8), .DATA_W(16), .DEPTH(4), .END_WORD(16'hFFFF)
    ) dut4 (
        .clk(clk), .reset(reset), .start(start), .bus(b4),
        .finish(fin4), .busy(busy4), .loaded_count(lc4), .truncated(tr4)
`ifdef PROGRAM_LOADER_READBACK_EN
        , .read_enable(re4), .read_address(ra4), .rb_data(rd4),
        .rb_valid(rv4), .register(reg4)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [23:0] wlog0[$];
    logic [23:0] wlog4[$];
    logic [7:0]  rbq0[$];
    int          fcnt0, fcnt4;

    always @(negedge clk) begin
        if (b0.we) wlog0.push_back({b0.instruct_dir, b0.instruction});
        if (b4.we) wlog4.push_back({b4.instruct_dir, b4.instruction});
        if (fin0) fcnt0++;
        if (fin4) fcnt4++;
`ifdef PROGRAM_LOADER_READBACK_EN
        if (rv0) rbq0.push_back(rd0);
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wlog0.delete();
        wlog4.delete();
        rbq0.delete();
        fcnt0 = 0;
        fcnt4 = 0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered and left at a negedge; holds valid until a handshake edge passes.
    task automatic send_byte(input logic [7:0] b, input logic rnd);
        int t = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                byte_valid = 1'b0;
                byte_in    = 8'hEE;
                tick();
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        while (!(sel4 ? b4.byte_ready : b0.byte_ready) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            errors++;
            checks++;
            $display("FAIL send_byte_timeout: got no byte_ready required byte_ready=1");
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((sel4 ? busy4 : busy0) && t < 200) begin
            tick();
            t++;
        end
        chk(name, 32'(t < 200), 32'd1);
    endtask

    typedef struct packed {
        logic [79:0] stream;
        logic [3:0]  nbytes;
        logic        rnd;
        logic [2:0]  nwords;
        logic [63:0] words;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{stream: {8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 32'h0},
                    nbytes: 4'd6, rnd: 1'b0, nwords: 3'd2,
                    words: {16'h1234, 16'hABCD, 32'h0}};
        vecs[1] = '{stream: {8'hFF, 8'hFF, 64'h0},
                    nbytes: 4'd2, rnd: 1'b0, nwords: 3'd0, words: 64'h0};
        vecs[2] = '{stream: {8'h00, 8'h01, 8'hFF, 8'hFE, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 16'h0},
                    nbytes: 4'd8, rnd: 1'b0, nwords: 3'd3,
                    words: {16'h0001, 16'hFFFE, 16'h7FFF, 16'h0}};
        vecs[3] = '{stream: {8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 32'h0},
                    nbytes: 4'd6, rnd: 1'b0, nwords: 3'd2,
                    words: {16'hFF00, 16'h00FF, 32'h0}};
        vecs[4] = '{stream: {8'hA5, 8'h5A, 8'h0F, 8'h0F, 8'hC3, 8'h3C, 8'hFF, 8'hFF, 16'h0},
                    nbytes: 4'd8, rnd: 1'b1, nwords: 3'd3,
                    words: {16'hA55A, 16'h0F0F, 16'hC33C, 16'h0}};
        vecs[5] = '{stream: {8'hFF, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'hFF, 32'h0},
                    nbytes: 4'd6, rnd: 1'b1, nwords: 3'd2,
                    words: {16'hFF12, 16'h34FF, 32'h0}};

        sel4 = 1'b0;
        do_reset();

        chk("reset_we",      32'(b0.we), 32'd0);
        chk("reset_instr",   32'(b0.instruction), 32'd0);
        chk("reset_dir",     32'(b0.instruct_dir), 32'd0);
        chk("reset_ready",   32'(b0.byte_ready), 32'd0);
        chk("reset_finish",  32'(fin0), 32'd0);
        chk("reset_busy",    32'(busy0), 32'd0);
        chk("reset_count",   32'(lc0), 32'd0);
        chk("reset_trunc",   32'(tr0), 32'd0);

        // Reset and start together: reset must win.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("reset_beats_start_busy", 32'(busy0), 32'd0);
        tick();
        chk("reset_beats_start_ready", 32'(b0.byte_ready), 32'd0);

        for (int v = 0; v < 6; v++) begin
            clear_logs();
            pulse_start();
            chk($sformatf("v%0d_busy_after_start", v), 32'(busy0), 32'd1);
            for (int i = 0; i < int'(vecs[v].nbytes); i++) begin
                send_byte(vecs[v].stream[79 - 8 * i -: 8], vecs[v].rnd);
            end
            wait_done($sformatf("v%0d_done_timeout", v));
            chk($sformatf("v%0d_write_count", v), 32'(wlog0.size()), 32'(vecs[v].nwords));
            for (int k = 0; k < int'(vecs[v].nwords) && k < wlog0.size(); k++) begin
                chk($sformatf("v%0d_write%0d", v, k), 32'(wlog0[k]),
                    {8'h00, 8'(k), vecs[v].words[63 - 16 * k -: 16]});
            end
            chk($sformatf("v%0d_finish_pulses", v), 32'(fcnt0), 32'd1);
            chk($sformatf("v%0d_loaded_count", v), 32'(lc0), 32'(vecs[v].nwords));
            chk($sformatf("v%0d_truncated", v), 32'(tr0), 32'd0);
            chk($sformatf("v%0d_ready_done", v), 32'(b0.byte_ready), 32'd0);
`ifdef PROGRAM_LOADER_READBACK_EN
            chk($sformatf("v%0d_rb_count", v), 32'(rbq0.size()), 32'd4);
            for (int r = 0; r < 4 && r < rbq0.size(); r++) begin
                chk($sformatf("v%0d_rb%0d", v, r), 32'(rbq0[r]), 32'((r + 1) * 16));
            end
`endif
        end

        // Write latency and ready turnaround around one low-byte handshake.
        clear_logs();
        pulse_start();
        send_byte(8'h12, 1'b0);
        byte_in    = 8'h34;
        byte_valid = 1'b1;
        chk("lat_ready_lo", 32'(b0.byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
        chk("lat_we_n1",    32'(b0.we), 32'd1);
        chk("lat_instr_n1", 32'(b0.instruction), 32'h1234);
        chk("lat_dir_n1",   32'(b0.instruct_dir), 32'd0);
        chk("lat_ready_n1", 32'(b0.byte_ready), 32'd0);
        tick();
        chk("lat_we_n2",    32'(b0.we), 32'd0);
        chk("lat_ready_n2", 32'(b0.byte_ready), 32'd1);
        chk("lat_instr_hold", 32'(b0.instruction), 32'h1234);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_done("lat_done_timeout");
        chk("lat_finish_pulses", 32'(fcnt0), 32'd1);

        // Reset after the high byte of the second word.
        clear_logs();
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_we",    32'(b0.we), 32'd0);
        chk("rst_mid_busy",  32'(busy0), 32'd0);
        chk("rst_mid_ready", 32'(b0.byte_ready), 32'd0);
        clear_logs();
        pulse_start();
        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_done("rst_mid_done_timeout");
        chk("rst_mid_write_count", 32'(wlog0.size()), 32'd1);
        if (wlog0.size() > 0) chk("rst_mid_write0", 32'(wlog0[0]), 32'h005555);
        chk("rst_mid_count", 32'(lc0), 32'd1);

        // DEPTH=4 overflow: four writes, then the fifth word is refused.
        do_reset();
        clear_logs();
        sel4 = 1'b1;
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b0);
        end
        byte_in    = 8'h09;
        byte_valid = 1'b1;
        begin
            logic any_ready = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (b4.byte_ready) any_ready = 1'b1;
                tick();
            end
            chk("ovf_ready_after_finish", 32'(any_ready), 32'd0);
        end
        byte_valid = 1'b0;
        wait_done("ovf_done_timeout");
        chk("ovf_write_count", 32'(wlog4.size()), 32'd4);
        for (int k = 0; k < 4 && k < wlog4.size(); k++) begin
            chk($sformatf("ovf_write%0d", k), 32'(wlog4[k]),
                {8'h00, 8'(k), 8'(2 * k + 1), 8'(2 * k + 2)});
        end
        chk("ovf_finish_pulses", 32'(fcnt4), 32'd1);
        chk("ovf_truncated",     32'(tr4), 32'd1);
        chk("ovf_count",         32'(lc4), 32'd4);
        chk("ovf_busy",          32'(busy4), 32'd0);
        sel4 = 1'b0;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
